// File: rtl/rust_controller.sv
// Baby-rocking controller: averages cry volume plus heart rate over a window and
// hill-climbs the rocking amplitude/frequency toward lower stress.
module rust_controller #(
   parameter int DATA_W   = 8,
   parameter int OUT_W    = 4,
   parameter int WIN_LOG2 = 2,
   parameter int SETTLE   = 16,
   parameter int CALM_TH  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] huilVolume,
   input  logic [DATA_W-1:0] hartRitme,
   output logic [OUT_W-1:0]  A,
   output logic [OUT_W-1:0]  F,
   output logic              calm,
   output logic              step
);

   // state      | meaning
   // ST_SETTLE  | wait SETTLE cycles after a step; window cleared
   // ST_MEASURE | accumulate 2^WIN_LOG2 valid samples
   // ST_DECIDE  | one cycle: calm check, hill-climb A or F

   localparam int STRESS_W = DATA_W + 1;
   localparam int ACC_W    = STRESS_W + WIN_LOG2;
   localparam int CNT_W    = $clog2(SETTLE + 1);
   localparam int NS_W     = WIN_LOG2 + 1;
   localparam logic [STRESS_W-1:0] CALM_V   = STRESS_W'(CALM_TH);
   localparam logic [CNT_W-1:0]    SET_LAST = CNT_W'(SETTLE - 1);
   localparam logic [NS_W-1:0]     WIN_LAST = NS_W'((2 ** WIN_LOG2) - 1);

   typedef enum logic [1:0] {ST_SETTLE, ST_MEASURE, ST_DECIDE} state_t;

   state_t              state;
   logic [CNT_W-1:0]    settle_cnt;
   logic [NS_W-1:0]     n_smp;
   logic [ACC_W-1:0]    acc;
   logic [STRESS_W-1:0] prev_stress;
   logic                axis;   // 0 selects A, 1 selects F
   logic                dir;    // 1 counts up

   logic [STRESS_W-1:0] stress;
   logic [STRESS_W-1:0] stress_avg;
   logic                improve;
   logic                next_axis;
   logic                next_dir;
   logic [OUT_W-1:0]    sel_val;
   logic [OUT_W-1:0]    moved;
   logic                at_lim;

   always_comb begin
      stress     = STRESS_W'(huilVolume) + STRESS_W'(hartRitme);
      stress_avg = acc[ACC_W-1:WIN_LOG2];
      improve    = stress_avg < prev_stress;
      next_axis  = improve ? axis : ~axis;
      next_dir   = improve ? dir : ~dir;
      sel_val    = next_axis ? F : A;
      at_lim     = next_dir ? (sel_val == '1) : (sel_val == '0);
      moved      = next_dir ? sel_val + OUT_W'(1) : sel_val - OUT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_SETTLE;
         settle_cnt  <= '0;
         n_smp       <= '0;
         acc         <= '0;
         prev_stress <= '1;
         axis        <= 1'b0;
         dir         <= 1'b1;
         A           <= '0;
         F           <= '0;
         calm        <= 1'b0;
         step        <= 1'b0;
      end else begin
         step <= 1'b0;
         case (state)
            ST_SETTLE: begin
               acc   <= '0;
               n_smp <= '0;
               if (settle_cnt == SET_LAST) begin
                  settle_cnt <= '0;
                  state      <= ST_MEASURE;
               end else begin
                  settle_cnt <= settle_cnt + CNT_W'(1);
               end
            end
            ST_MEASURE: begin
               if (sample_valid) begin
                  acc   <= acc + ACC_W'(stress);
                  n_smp <= n_smp + NS_W'(1);
                  if (n_smp == WIN_LAST) state <= ST_DECIDE;
               end
            end
            ST_DECIDE: begin
               state <= ST_SETTLE;
               if (stress_avg < CALM_V) begin
                  calm <= 1'b1;
               end else begin
                  calm        <= 1'b0;
                  prev_stress <= stress_avg;
                  axis        <= next_axis;
                  // saturated axis holds and reverses instead of stepping
                  if (at_lim) begin
                     dir <= ~next_dir;
                  end else begin
                     dir  <= next_dir;
                     step <= 1'b1;
                     if (next_axis) F <= moved;
                     else           A <= moved;
                  end
               end
            end
            default: state <= ST_SETTLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rust_controller.sv
// Directed bench for rust_controller: fixed-length windows with hand-computed
// A/F/calm/step expectations, including saturation, calm threshold and mid-window reset.
module tb_rust_controller;

   logic       clk;
   logic       reset;
   logic       sample_valid;
   logic [7:0] huilVolume;
   logic [7:0] hartRitme;
   logic [3:0] A;
   logic [3:0] F;
   logic       calm;
   logic       step;

   int n_cmp = 0;
   int n_bad = 0;
   int wn    = 0;
   logic [3:0] cur_a = 4'd0;
   logic [3:0] cur_f = 4'd0;

   rust_controller dut (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .huilVolume   (huilVolume),
      .hartRitme    (hartRitme),
      .A            (A),
      .F            (F),
      .calm         (calm),
      .step         (step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] h, input logic [7:0] r);
      @(negedge clk);
      sample_valid = v;
      huilVolume   = h;
      hartRitme    = r;
   endtask

   // one full SETTLE + MEASURE + DECIDE pass; junk 255/255 is offered while it must be ignored
   task automatic window(input logic [7:0] h, input logic [7:0] r, input bit inc, input bit gap,
                         input logic [3:0] ea, input logic [3:0] ef, input logic ec, input logic es);
      wn++;
      for (int i = 0; i < 16; i++) drive(1'b1, 8'd255, 8'd255);
      for (int i = 0; i < 4; i++) begin
         if (gap) drive(1'b0, 8'd255, 8'd255);
         drive(1'b1, inc ? 8'(h + 8'(i)) : h, r);
      end
      drive(1'b1, 8'd255, 8'd255);
      check($sformatf("w%0d_pre_a", wn), 32'(A), 32'(cur_a));
      check($sformatf("w%0d_pre_f", wn), 32'(F), 32'(cur_f));
      check($sformatf("w%0d_pre_step", wn), 32'(step), 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("w%0d_a", wn), 32'(A), 32'(ea));
      check($sformatf("w%0d_f", wn), 32'(F), 32'(ef));
      check($sformatf("w%0d_calm", wn), 32'(calm), 32'(ec));
      check($sformatf("w%0d_step", wn), 32'(step), 32'(es));
      cur_a = ea;
      cur_f = ef;
   endtask

   initial begin
      reset        = 1'b0;
      sample_valid = 1'b0;
      huilVolume   = 8'd0;
      hartRitme    = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_a", 32'(A), 32'd0);
      check("rst_f", 32'(F), 32'd0);
      check("rst_calm", 32'(calm), 32'd0);
      check("rst_step", 32'(step), 32'd0);
      reset = 1'b1;

      window(8'd100, 8'd100, 0, 0, 4'd1, 4'd0, 1'b0, 1'b1);  // 200 first window always improves
      window(8'd90,  8'd90,  0, 1, 4'd2, 4'd0, 1'b0, 1'b1);  // 180, invalid gaps between samples
      window(8'd80,  8'd80,  0, 0, 4'd3, 4'd0, 1'b0, 1'b1);  // 160
      window(8'd85,  8'd85,  0, 0, 4'd3, 4'd0, 1'b0, 1'b0);  // 170 worse: F down from 0 saturates
      window(8'd80,  8'd80,  0, 0, 4'd3, 4'd1, 1'b0, 1'b1);  // 160 better: F up
      window(8'd10,  8'd10,  0, 0, 4'd3, 4'd1, 1'b1, 1'b0);  // 20 calm
      window(8'd70,  8'd80,  0, 0, 4'd3, 4'd2, 1'b0, 1'b1);  // 150 < 160
      window(8'd75,  8'd75,  0, 0, 4'd2, 4'd2, 1'b0, 1'b1);  // 150 equal: swap to A, down
      window(8'd70,  8'd78,  1, 0, 4'd1, 4'd2, 1'b0, 1'b1);  // 148..151 -> 149 truncated
      window(8'd74,  8'd75,  0, 0, 4'd1, 4'd3, 1'b0, 1'b1);  // 149 equal: swap to F, up
      window(8'd15,  8'd16,  0, 0, 4'd1, 4'd3, 1'b1, 1'b0);  // 31 just below threshold

      // reset after two samples of a window
      for (int i = 0; i < 16; i++) drive(1'b1, 8'd255, 8'd255);
      drive(1'b1, 8'd100, 8'd100);
      drive(1'b1, 8'd100, 8'd100);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid_rst_a", 32'(A), 32'd0);
      check("mid_rst_f", 32'(F), 32'd0);
      check("mid_rst_calm", 32'(calm), 32'd0);
      check("mid_rst_step", 32'(step), 32'd0);
      cur_a = 4'd0;
      cur_f = 4'd0;
      @(posedge clk);
      #1;
      reset = 1'b1;

      window(8'd255, 8'd255, 0, 0, 4'd1, 4'd0, 1'b0, 1'b1);  // 510 < all-ones
      window(8'd255, 8'd0,   0, 0, 4'd2, 4'd0, 1'b0, 1'b1);  // 255 < 510
      for (int k = 0; k <= 12; k++)
         window(8'(120 - k), 8'(120 - k), 0, 0, 4'(3 + k), 4'd0, 1'b0, 1'b1);
      window(8'd107, 8'd107, 0, 0, 4'd15, 4'd0, 1'b0, 1'b0); // A at 15: hold, reverse
      window(8'd106, 8'd106, 0, 0, 4'd14, 4'd0, 1'b0, 1'b1);
      window(8'd15,  8'd16,  0, 0, 4'd14, 4'd0, 1'b1, 1'b0); // 31 calm
      window(8'd16,  8'd16,  0, 0, 4'd13, 4'd0, 1'b0, 1'b1); // 32 at threshold: not calm

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
